ps2_keyboard_rx: RTL



---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_keyboard_rx_if.sv | 38 +++
 rtl/ps2_line_filter.sv | 63 ++++++
 rtl/ps2_keyboard_rx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and FSM state type for the PS/2 keyboard receiver
//
// Purpose: prefix and arrow scan codes, frame length and receiver FSM states.
// Ports:   none (package).
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;

  localparam logic [7:0] PS2_UP    = 8'h75;
  localparam logic [7:0] PS2_DOWN  = 8'h72;
  localparam logic [7:0] PS2_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_RIGHT = 8'h74;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// rtl/ps2_keyboard_rx_if.sv - pad lines and decoded key outputs of the PS/2 receiver
//
// Purpose: groups the raw PS/2 lines and the decoded scan/key outputs.
// Ports (signals):
//   ps2_clk, ps2_data       raw PS/2 lines from the pads (read only by the receiver)
//   scan_code[7:0]          last make/break code, prefixes stripped
//   scan_valid              one-cycle pulse when scan_code/extended/released update
//   extended, released      code was preceded by E0 / F0
//   frame_error             one-cycle pulse on a bad frame or a timeout
//   key_up/down/left/right  held state of the four extended arrow keys
// Modports: master = receiver side, slave = pad driver / key consumer side.
interface ps2_keyboard_rx_if;

  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       extended;
  logic       released;
  logic       frame_error;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;

  modport master (
    input  ps2_clk, ps2_data,
    output scan_code, scan_valid, extended, released, frame_error,
    output key_up, key_down, key_left, key_right
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  scan_code, scan_valid, extended, released, frame_error,
    input  key_up, key_down, key_left, key_right
  );

endinterface

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchronizer, glitch filter and falling-edge pulse for one PS/2 line
//
// Purpose: brings an asynchronous line into the clk domain, ignores level changes
//          shorter than FILTER_LEN cycles and pulses once per filtered 1->0 edge.
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset (filtered level returns to 1)
//   line_in     raw asynchronous line
//   fall_pulse  one-cycle pulse, high in the first cycle the filtered level is 0
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic fall_pulse
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             filt_q,  filt_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             fall_q,  fall_d;

  always_comb begin
    sync1_d = line_in;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    fall_d  = 1'b0;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
      // FILTER_LEN-th consecutive cycle at the opposite level: accept it
      filt_d = sync2_q;
      cnt_d  = '0;
      fall_d = ~sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign fall_pulse = fall_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - host-side PS/2 keyboard receiver with arrow-key held flags
//
// Purpose: deframes 11-bit PS/2 frames, strips E0/F0 prefixes and keeps held
//          flags for the four extended arrow keys.
// Ports:
//   clk    100 MHz system clock
//   reset  synchronous, active-high reset
//   bus    ps2_keyboard_rx_if.master: ps2_clk/ps2_data in; scan_code, scan_valid,
//          extended, released, frame_error, key_up/down/left/right out
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic               clk,
  input logic               reset,
  ps2_keyboard_rx_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic sample_en;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk        (clk),
    .reset      (reset),
    .line_in    (bus.ps2_clk),
    .fall_pulse (sample_en)
  );

  rx_state_e   state_q,       state_d;
  logic        data_sync1_q,  data_sync1_d;
  logic        data_sync2_q,  data_sync2_d;
  logic [3:0]  bit_cnt_q,     bit_cnt_d;
  logic [9:0]  shift_q,       shift_d;
  logic [TO_W-1:0] timeout_q, timeout_d;
  logic        ext_pend_q,    ext_pend_d;
  logic        brk_pend_q,    brk_pend_d;
  logic [7:0]  scan_code_q,   scan_code_d;
  logic        scan_valid_q,  scan_valid_d;
  logic        extended_q,    extended_d;
  logic        released_q,    released_d;
  logic        frame_error_q, frame_error_d;
  logic        key_up_q,      key_up_d;
  logic        key_down_q,    key_down_d;
  logic        key_left_q,    key_left_d;
  logic        key_right_q,   key_right_d;

  // shift_q after 10 samples: [7:0] data, [8] odd parity, [9] stop
  logic [7:0] rx_byte;
  logic       frame_ok;
  assign rx_byte  = shift_q[7:0];
  assign frame_ok = shift_q[9] & (^shift_q[8:0]);

  always_comb begin
    state_d       = state_q;
    data_sync1_d  = bus.ps2_data;
    data_sync2_d  = data_sync1_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    timeout_d     = timeout_q;
    ext_pend_d    = ext_pend_q;
    brk_pend_d    = brk_pend_q;
    scan_code_d   = scan_code_q;
    scan_valid_d  = 1'b0;
    extended_d    = extended_q;
    released_d    = released_q;
    frame_error_d = 1'b0;
    key_up_d      = key_up_q;
    key_down_d    = key_down_q;
    key_left_d    = key_left_q;
    key_right_d   = key_right_q;

    case (state_q)
      IDLE: begin
        timeout_d = '0;
        bit_cnt_d = '0;
        if (sample_en) begin
          if (!data_sync2_q) begin
            state_d   = SHIFT;
            bit_cnt_d = 4'd1;
          end else begin
            frame_error_d = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (sample_en) begin
          shift_d   = {data_sync2_q, shift_q[9:1]};
          timeout_d = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
            state_d = CHECK;
          end
        end else if (timeout_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = IDLE;
          timeout_d     = '0;
          frame_error_d = 1'b1;
          ext_pend_d    = 1'b0;
          brk_pend_d    = 1'b0;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end

      CHECK: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        if (!frame_ok) begin
          frame_error_d = 1'b1;
          ext_pend_d    = 1'b0;
          brk_pend_d    = 1'b0;
        end else if (rx_byte == PS2_EXT) begin
          ext_pend_d = 1'b1;
        end else if (rx_byte == PS2_BRK) begin
          brk_pend_d = 1'b1;
        end else begin
          scan_code_d  = rx_byte;
          extended_d   = ext_pend_q;
          released_d   = brk_pend_q;
          scan_valid_d = 1'b1;
          ext_pend_d   = 1'b0;
          brk_pend_d   = 1'b0;
          // Only E0-prefixed arrow codes touch the held flags
          if (ext_pend_q) begin
            case (rx_byte)
              PS2_UP:    key_up_d    = ~brk_pend_q;
              PS2_DOWN:  key_down_d  = ~brk_pend_q;
              PS2_LEFT:  key_left_d  = ~brk_pend_q;
              PS2_RIGHT: key_right_d = ~brk_pend_q;
              default: ;
            endcase
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      data_sync1_q  <= 1'b1;
      data_sync2_q  <= 1'b1;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      timeout_q     <= '0;
      ext_pend_q    <= 1'b0;
      brk_pend_q    <= 1'b0;
      scan_code_q   <= '0;
      scan_valid_q  <= 1'b0;
      extended_q    <= 1'b0;
      released_q    <= 1'b0;
      frame_error_q <= 1'b0;
      key_up_q      <= 1'b0;
      key_down_q    <= 1'b0;
      key_left_q    <= 1'b0;
      key_right_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_sync1_q  <= data_sync1_d;
      data_sync2_q  <= data_sync2_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      timeout_q     <= timeout_d;
      ext_pend_q    <= ext_pend_d;
      brk_pend_q    <= brk_pend_d;
      scan_code_q   <= scan_code_d;
      scan_valid_q  <= scan_valid_d;
      extended_q    <= extended_d;
      released_q    <= released_d;
      frame_error_q <= frame_error_d;
      key_up_q      <= key_up_d;
      key_down_q    <= key_down_d;
      key_left_q    <= key_left_d;
      key_right_q   <= key_right_d;
    end
  end

  assign bus.scan_code   = scan_code_q;
  assign bus.scan_valid  = scan_valid_q;
  assign bus.extended    = extended_q;
  assign bus.released    = released_q;
  assign bus.frame_error = frame_error_q;
  assign bus.key_up      = key_up_q;
  assign bus.key_down    = key_down_q;
  assign bus.key_left    = key_left_q;
  assign bus.key_right   = key_right_q;

endmodule
